// File: rtl/multicycle_ctrl_if.sv
// Handshake and control bundle between the multicycle controller and its datapath/memories.
// The instret counter port only exists when PERF_CNT_EN is defined.
interface multicycle_ctrl_if;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] instr;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        pc_sel;
  logic        a_sel;
  logic        b_sel;
  logic        branch;
  logic [4:0]  alu_sel;
  logic        ir_we;
  logic        pc_we;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        fault;
  logic        illegal;
`ifdef PERF_CNT_EN
  logic [31:0] instret;
`endif

  modport master (
    output imem_req, dmem_req, dmem_we, a_sel, b_sel, branch, alu_sel,
           ir_we, pc_we, rf_we, wb_sel, fault, illegal,
`ifdef PERF_CNT_EN
    output instret,
`endif
    input  imem_ack, instr, dmem_ack, pc_sel
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we, a_sel, b_sel, branch, alu_sel,
           ir_we, pc_we, rf_we, wb_sel, fault, illegal,
`ifdef PERF_CNT_EN
    input  instret,
`endif
    output imem_ack, instr, dmem_ack, pc_sel
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM with fetch/data wait timeout and sticky fault.
// Define PERF_CNT_EN to add the retired-instruction counter (instret).
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clock,
  input  logic             reset,
  multicycle_ctrl_if.master bus
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, FAULT} state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] ONE = 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [31:0]   ir_q, ir_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          illegal_q, illegal_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       legal, is_load, is_store, is_branch, is_jump;
  logic       dec_a_sel, dec_b_sel;
  logic [4:0] dec_alu;
  logic       timeout;
  logic       unused_bits;

  assign opcode      = ir_q[6:0];
  assign funct3      = ir_q[14:12];
  assign funct7b5    = ir_q[30];
  assign unused_bits = ^{ir_q[31], ir_q[29:15], ir_q[11:7], bus.pc_sel};
  assign timeout     = (TIMEOUT_CYCLES != 0) && (wait_q == TO_LAST);

  always_comb begin
    legal     = 1'b1;
    dec_alu   = 5'b00000;
    dec_a_sel = 1'b0;
    dec_b_sel = 1'b0;
    is_load   = (opcode == OPC_LOAD);
    is_store  = (opcode == OPC_STORE);
    is_branch = (opcode == OPC_BRANCH);
    is_jump   = (opcode == OPC_JAL) || (opcode == OPC_JALR);
    case (opcode)
      OPC_LUI:   dec_alu = 5'b10000;
      OPC_AUIPC: begin dec_a_sel = 1'b1; dec_b_sel = 1'b1; end
      OPC_JAL:   dec_alu = 5'b01110;
      OPC_JALR:  dec_alu = 5'b01111;
      OPC_LOAD, OPC_STORE: dec_b_sel = 1'b1;
      OPC_BRANCH: begin
        case (funct3)
          3'b000:  dec_alu = 5'b01100;
          3'b001:  dec_alu = 5'b01101;
          3'b100:  dec_alu = 5'b01010;
          3'b101:  dec_alu = 5'b01011;
          3'b110:  dec_alu = 5'b01000;
          3'b111:  dec_alu = 5'b01001;
          default: legal = 1'b0;
        endcase
      end
      OPC_OP, OPC_OPIMM: begin
        dec_b_sel = (opcode == OPC_OPIMM);
        case (funct3)
          3'b000:  dec_alu = (opcode == OPC_OP && funct7b5) ? 5'b00001 : 5'b00000;
          3'b001:  dec_alu = 5'b00101;
          3'b010:  dec_alu = 5'b01010;
          3'b011:  dec_alu = 5'b01000;
          3'b100:  dec_alu = 5'b00100;
          3'b101:  dec_alu = funct7b5 ? 5'b00111 : 5'b00110;
          3'b110:  dec_alu = 5'b00011;
          default: dec_alu = 5'b00010;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  // Next state; the wait counter only survives while the state is unchanged.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    wait_d    = wait_q;
    illegal_d = illegal_q;
    case (state_q)
      FETCH: begin
        if (bus.imem_ack) begin
          ir_d    = bus.instr;
          state_d = DECODE;
        end else if (timeout) begin
          state_d = FAULT;
        end else if (TIMEOUT_CYCLES != 0) begin
          wait_d = wait_q + ONE;
        end
      end
      DECODE: begin
        if (legal) begin
          state_d = EXEC;
        end else begin
          state_d   = FAULT;
          illegal_d = 1'b1;
        end
      end
      EXEC: begin
        if (is_branch)                state_d = FETCH;
        else if (is_load || is_store) state_d = MEM;
        else                          state_d = WB;
      end
      MEM: begin
        if (bus.dmem_ack) begin
          state_d = is_store ? FETCH : WB;
        end else if (timeout) begin
          state_d = FAULT;
        end else if (TIMEOUT_CYCLES != 0) begin
          wait_d = wait_q + ONE;
        end
      end
      WB:      state_d = FETCH;
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase
    if (state_d != state_q) wait_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= FETCH;
      ir_q      <= '0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
    end
  end

  // Reset forces every output low immediately so an aborted access cannot pulse an enable.
  always_comb begin
    bus.imem_req = 1'b0;
    bus.ir_we    = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    bus.a_sel    = 1'b0;
    bus.b_sel    = 1'b0;
    bus.branch   = 1'b0;
    bus.alu_sel  = 5'b00000;
    bus.pc_we    = 1'b0;
    bus.rf_we    = 1'b0;
    bus.wb_sel   = 2'b00;
    bus.fault    = 1'b0;
    bus.illegal  = 1'b0;
    if (!reset) begin
      if (state_q == DECODE || state_q == EXEC || state_q == MEM || state_q == WB) begin
        bus.a_sel   = dec_a_sel;
        bus.b_sel   = dec_b_sel;
        bus.branch  = is_branch;
        bus.alu_sel = dec_alu;
      end
      case (state_q)
        FETCH: begin
          bus.imem_req = 1'b1;
          bus.ir_we    = bus.imem_ack;
        end
        EXEC: bus.pc_we = is_branch;
        MEM: begin
          bus.dmem_req = 1'b1;
          bus.dmem_we  = is_store;
          bus.pc_we    = is_store && bus.dmem_ack;
        end
        WB: begin
          bus.rf_we  = 1'b1;
          bus.pc_we  = 1'b1;
          bus.wb_sel = is_load ? 2'b01 : (is_jump ? 2'b10 : 2'b00);
        end
        FAULT: begin
          bus.fault   = 1'b1;
          bus.illegal = illegal_q;
        end
        default: ;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] instret_q;

  always_ff @(posedge clock) begin
    if (reset)           instret_q <= '0;
    else if (bus.pc_we)  instret_q <= instret_q + 32'd1;
  end

  assign bus.instret = instret_q;
`endif
endmodule
